arith_seq_machine: RTL

//   Parametrised successor to the single-cycle arithmetic machine. Fetches MIPS-style

---
 rtl/arith_seq_machine_pkg.sv | 43 ++++
 rtl/arith_seq_machine_if.sv | 10 +
 rtl/arith_seq_machine_decode.sv | 66 ++++++
 rtl/arith_seq_machine.sv | 126 ++++++++++++
 4 files changed

// File: rtl/arith_seq_machine_pkg.sv
// Shared definitions for the sequential arithmetic machine: opcodes, functs,
// ALU op codes, exception causes, FSM states and the decoded-instruction bundle.
package arith_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR
  } alu_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0, EXC_ILL = 2'd1, EXC_OVF = 2'd2
  } exc_e;

  typedef enum logic [1:0] {
    FETCH, EXEC, HALT
  } state_e;

  typedef struct packed {
    logic [4:0] dest;
    logic       we;
    logic       use_imm;
    logic       imm_sext;
    alu_op_e    op;
    logic       illegal;
    logic       ovf_chk;
  } dec_t;

endpackage

// File: rtl/arith_seq_machine_if.sv
// Instruction-fetch port: req held until ack, data valid with ack.
interface arith_seq_machine_if #(parameter int PC_W = 32);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/arith_seq_machine_decode.sv
// Combinational instruction decode: destination, write enable, immediate
// handling, ALU op, and legality against the configured register count.
module arith_seq_decode
  import arith_defs::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, shamt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign fn    = ir[5:0];

  // A register field naming a register beyond NREGS makes the word illegal.
  function automatic logic hi_nz(input logic [4:0] f);
    return (f >> REG_AW) != 5'd0;
  endfunction

  always_comb begin
    dec = '0;
    dec.op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec.dest = rd;
        dec.we   = 1'b1;
        case (fn)
          FN_ADD:  begin dec.op = ALU_ADD; dec.ovf_chk = 1'b1; end
          FN_ADDU: dec.op = ALU_ADD;
          FN_SUB:  begin dec.op = ALU_SUB; dec.ovf_chk = 1'b1; end
          FN_SUBU: dec.op = ALU_SUB;
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_XOR:  dec.op = ALU_XOR;
          FN_NOR:  dec.op = ALU_NOR;
          default: dec.illegal = 1'b1;
        endcase
        if (shamt != 5'd0 || hi_nz(rs) || hi_nz(rt) || hi_nz(rd)) dec.illegal = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec.dest     = rt;
        dec.we       = 1'b1;
        dec.use_imm  = 1'b1;
        dec.imm_sext = (op == OP_ADDI) || (op == OP_ADDIU);
        dec.ovf_chk  = (op == OP_ADDI);
        case (op)
          OP_ANDI: dec.op = ALU_AND;
          OP_ORI:  dec.op = ALU_OR;
          OP_XORI: dec.op = ALU_XOR;
          default: dec.op = ALU_ADD;
        endcase
        if (hi_nz(rs) || hi_nz(rt)) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.we = 1'b0;
  end

endmodule

// File: rtl/arith_seq_machine.sv
// FETCH->EXEC arithmetic machine: fetches over a req/ack port, executes one
// instruction per EXEC cycle, and halts stickily on illegal or trapped overflow.
module arith_seq_machine
  import arith_defs::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 32,
  parameter int TRAP_OVF = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  arith_seq_machine_if.master  imem,
  output logic                 retire,
  output logic                 except,
  output logic [1:0]           except_code,
  output logic                 halted,
  input  logic [REG_AW-1:0]    dbg_raddr,
  output logic [DATA_W-1:0]    dbg_rdata
);

  localparam int NREGS = 1 << REG_AW;
  localparam int MSB   = DATA_W - 1;

  state_e                          state_q, state_d;
  logic [PC_W-1:0]                 pc_q, pc_d;
  logic [31:0]                     ir_q, ir_d;
  exc_e                            code_q, code_d;
  logic [NREGS-1:0][DATA_W-1:0]    regs_q, regs_d;

  dec_t              dec;
  logic [REG_AW-1:0] rs_idx, rt_idx, wr_idx;
  logic [DATA_W-1:0] opa, opb, imm, alu_res;
  logic              ovf, trap, wr_en;

  arith_seq_decode #(.REG_AW(REG_AW)) u_dec (.ir(ir_q), .dec(dec));

  assign rs_idx = ir_q[21 +: REG_AW];
  assign rt_idx = ir_q[16 +: REG_AW];
  assign wr_idx = dec.dest[REG_AW-1:0];
  assign imm    = dec.imm_sext ? DATA_W'($signed(ir_q[15:0])) : DATA_W'(ir_q[15:0]);
  assign opa    = regs_q[rs_idx];
  assign opb    = dec.use_imm ? imm : regs_q[rt_idx];

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (dec.op)
      ALU_ADD: begin
        alu_res = opa + opb;
        ovf     = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      ALU_SUB: begin
        alu_res = opa - opb;
        ovf     = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_XOR: alu_res = opa ^ opb;
      ALU_NOR: alu_res = ~(opa | opb);
      default: alu_res = '0;
    endcase
  end

  assign trap = (TRAP_OVF != 0) && dec.ovf_chk && ovf;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    code_d  = code_q;
    wr_en   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH: if (imem.imem_ack) begin
        ir_d    = imem.imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (dec.illegal) begin
          code_d  = EXC_ILL;
          state_d = HALT;
        end else if (trap) begin
          code_d  = EXC_OVF;
          state_d = HALT;
        end else begin
          wr_en   = dec.we && (wr_idx != '0);
          pc_d    = pc_q + PC_W'(4);
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_idx] = alu_res;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      code_q  <= EXC_NONE;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      code_q  <= code_d;
      regs_q  <= regs_d;
    end
  end

  // Gating with reset drops the request the instant reset asserts.
  assign imem.imem_req  = reset && (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign except         = (code_q != EXC_NONE);
  assign except_code    = code_q;
  assign halted         = (state_q == HALT);
  assign dbg_rdata      = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

endmodule
